// File: rtl/tmds_encoder_dvi.sv
// TMDS encoder for one DVI/HDMI colour channel.
// Stage p1 holds the transition-minimised word q_m. Stage p2 applies DC balance
// against the running disparity and registers the 10-bit character.
// Bit 0 of o_tmds is the first bit sent on the wire.
module tmds_encoder_dvi (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_data,
   input  logic [1:0] i_ctrl,
   input  logic       i_de,
   output logic [9:0] o_tmds
);

   localparam logic [9:0] CTRL_00 = 10'b1101010100;
   localparam logic [9:0] CTRL_01 = 10'b0010101011;
   localparam logic [9:0] CTRL_10 = 10'b0101010100;
   localparam logic [9:0] CTRL_11 = 10'b1010101011;

   // Population count of a byte (0..8).
   function automatic logic [3:0] f_ones8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

   // ---- stage p0 -> p1: transition minimisation ----
   logic [3:0] w_n1d_p0;
   logic       w_use_xnor_p0;
   logic [8:0] w_qm_p0;

   logic [8:0] r_qm_p1;
   logic       r_de_p1;
   logic [1:0] r_ctrl_p1;

   // XOR/XNOR chain over the input byte; q_m[8] records which chain was used.
   always_comb begin
      w_n1d_p0      = f_ones8(i_data);
      w_use_xnor_p0 = (w_n1d_p0 > 4'd4) || ((w_n1d_p0 == 4'd4) && !i_data[0]);
      w_qm_p0       = 9'd0;
      w_qm_p0[0]    = i_data[0];
      for (int i = 1; i < 8; i++) begin
         if (w_use_xnor_p0) begin
            w_qm_p0[i] = ~(w_qm_p0[i-1] ^ i_data[i]);
         end else begin
            w_qm_p0[i] = w_qm_p0[i-1] ^ i_data[i];
         end
      end
      w_qm_p0[8] = ~w_use_xnor_p0;
   end

   // Stage p1 register; reset leaves a control-00 slot so nothing stale escapes.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_qm_p1   <= 9'd0;
         r_de_p1   <= 1'b0;
         r_ctrl_p1 <= 2'b00;
      end else begin
         r_qm_p1   <= w_qm_p0;
         r_de_p1   <= i_de;
         r_ctrl_p1 <= i_ctrl;
      end
   end

   // ---- stage p1 -> p2: DC balance ----
   logic [3:0]        w_n1_p1;
   logic signed [5:0] w_disp_p1;
   logic signed [5:0] w_cnt_ext_p1;
   logic signed [5:0] w_cnt_nxt_p1;
   logic [9:0]        w_tmds_p1;

   logic signed [4:0] r_cnt_p2;
   logic [9:0]        r_tmds_p2;

   // Choose inversion to steer disparity toward zero; control periods clear it.
   // All disparity terms are 6-bit signed; |cnt| stays within 10.
   always_comb begin
      w_n1_p1      = f_ones8(r_qm_p1[7:0]);
      // n1 - n0 = 2*n1 - 8
      w_disp_p1    = $signed({1'b0, w_n1_p1, 1'b0}) - 6'sd8;
      w_cnt_ext_p1 = {r_cnt_p2[4], r_cnt_p2};
      w_cnt_nxt_p1 = 6'sd0;
      w_tmds_p1    = CTRL_00;
      if (!r_de_p1) begin
         w_cnt_nxt_p1 = 6'sd0;
         case (r_ctrl_p1)
            2'b00:   w_tmds_p1 = CTRL_00;
            2'b01:   w_tmds_p1 = CTRL_01;
            2'b10:   w_tmds_p1 = CTRL_10;
            default: w_tmds_p1 = CTRL_11;
         endcase
      end else if ((r_cnt_p2 == 5'sd0) || (w_disp_p1 == 6'sd0)) begin
         w_tmds_p1 = {~r_qm_p1[8], r_qm_p1[8],
                      r_qm_p1[8] ? r_qm_p1[7:0] : ~r_qm_p1[7:0]};
         w_cnt_nxt_p1 = r_qm_p1[8] ? (w_cnt_ext_p1 + w_disp_p1)
                                   : (w_cnt_ext_p1 - w_disp_p1);
      end else if (((r_cnt_p2 > 5'sd0) && (w_disp_p1 > 6'sd0)) ||
                   ((r_cnt_p2 < 5'sd0) && (w_disp_p1 < 6'sd0))) begin
         w_tmds_p1    = {1'b1, r_qm_p1[8], ~r_qm_p1[7:0]};
         w_cnt_nxt_p1 = w_cnt_ext_p1 + (r_qm_p1[8] ? 6'sd2 : 6'sd0) - w_disp_p1;
      end else begin
         w_tmds_p1    = {1'b0, r_qm_p1[8], r_qm_p1[7:0]};
         w_cnt_nxt_p1 = w_cnt_ext_p1 + w_disp_p1 - (r_qm_p1[8] ? 6'sd0 : 6'sd2);
      end
   end

   // Stage p2 register: character and running disparity update together.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt_p2  <= 5'sd0;
         r_tmds_p2 <= CTRL_00;
      end else begin
         r_cnt_p2  <= w_cnt_nxt_p1[4:0];
         r_tmds_p2 <= w_tmds_p1;
      end
   end

   assign o_tmds = r_tmds_p2;

endmodule

// File: tb/tb_tmds_encoder_dvi.sv
// Scoreboard bench for tmds_encoder_dvi: directed sequences then a random soak
// with occasional mid-stream resets, checked against a behavioural model.
module tb_tmds_encoder_dvi;

   logic       clk;
   logic       rst;
   logic [7:0] data;
   logic [1:0] ctrl;
   logic       de;
   logic [9:0] tmds;

   tmds_encoder_dvi dut (
      .i_clk (clk),
      .i_rst (rst),
      .i_data(data),
      .i_ctrl(ctrl),
      .i_de  (de),
      .o_tmds(tmds)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] out;
      int         cnt;
      logic       de;
      logic [7:0] data;
      logic       kv;
      logic [9:0] kout;
   } exp_t;

   exp_t q[$];
   int   m_cnt  = 0;
   int   n_chk  = 0;
   int   n_pass = 0;
   bit   mon_on = 1'b0;

   logic [9:0] CTRL_CODES [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

   // Behavioural encoder: one character from the rules, tracking disparity in an int.
   task automatic encode(input logic e, input logic [7:0] d, input logic [1:0] c,
                         output logic [9:0] o);
      int n1d, n1, n0;
      logic [8:0] qm;
      if (!e) begin
         m_cnt = 0;
         o = CTRL_CODES[c];
      end else begin
         n1d = $countones(d);
         qm = '0;
         qm[0] = d[0];
         if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
         end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
         end
         n1 = $countones(qm[7:0]);
         n0 = 8 - n1;
         if (m_cnt == 0 || n1 == n0) begin
            o = qm[8] ? {2'b01, qm[7:0]} : {2'b10, ~qm[7:0]};
            m_cnt += qm[8] ? (n1 - n0) : (n0 - n1);
         end else if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1)) begin
            o = {1'b1, qm[8], ~qm[7:0]};
            m_cnt += (qm[8] ? 2 : 0) + (n0 - n1);
         end else begin
            o = {1'b0, qm[8], qm[7:0]};
            m_cnt += (n1 - n0) - (qm[8] ? 0 : 2);
         end
      end
   endtask

   function automatic logic [7:0] decode(input logic [9:0] t);
      logic [7:0] qd, d;
      qd = t[9] ? ~t[7:0] : t[7:0];
      d[0] = qd[0];
      for (int i = 1; i < 8; i++) d[i] = t[8] ? (qd[i] ^ qd[i-1]) : ~(qd[i] ^ qd[i-1]);
      return d;
   endfunction

   // Drive one cycle of input and push the expected output(s) for it.
   task automatic step(input logic r, input logic e, input logic [7:0] d,
                       input logic [1:0] c, input logic kv, input logic [9:0] kout);
      exp_t x;
      @(negedge clk);
      rst = r; de = e; data = d; ctrl = c;
      if (r) begin
         q.delete();
         m_cnt = 0;
         x = '{out: 10'h354, cnt: 0, de: 1'b0, data: 8'h00, kv: 1'b1, kout: 10'h354};
         q.push_back(x);
         q.push_back(x);
      end else begin
         x.de = e; x.data = d; x.kv = kv; x.kout = kout;
         encode(e, d, c, x.out);
         x.cnt = m_cnt;
         q.push_back(x);
      end
      mon_on = 1'b1;
   endtask

   task automatic chk(input string name, input int act, input int req);
      n_chk++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got 0x%0h (%0d) required 0x%0h (%0d) at %0t",
                    name, act, act, req, req, $time);
   endtask

   // Monitor: pop one expected character per edge and compare.
   initial begin
      exp_t x;
      int dc;
      forever begin
         @(posedge clk);
         #1;
         if (mon_on) begin
            if (q.size() == 0) begin
               chk("queue_empty", 1, 0);
            end else begin
               x = q.pop_front();
               dc = dut.r_cnt_p2;
               chk("out", int'(tmds), int'(x.out));
               chk("cnt", dc, x.cnt);
               chk("cnt_bound", int'(dc <= 10 && dc >= -10), 1);
               if (x.kv) chk("known", int'(tmds), int'(x.kout));
               if (x.de) chk("decode", int'(decode(tmds)), int'(x.data));
            end
         end
      end
   end

   initial begin
      int rst_left;
      rst = 1'b1; de = 1'b0; data = 8'h00; ctrl = 2'b00;
      // Reset with random inputs, then release into control 00.
      for (int i = 0; i < 4; i++)
         step(1'b1, 1'($urandom), 8'($urandom), 2'($urandom), 1'b0, 10'h0);
      step(1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 10'h354);
      step(1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 10'h354);
      // Control codes.
      step(1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 10'h354);
      step(1'b0, 1'b0, 8'h00, 2'b01, 1'b1, 10'h0AB);
      step(1'b0, 1'b0, 8'h00, 2'b10, 1'b1, 10'h154);
      step(1'b0, 1'b0, 8'h00, 2'b11, 1'b1, 10'h2AB);
      // DC balance on zeros.
      step(1'b0, 1'b1, 8'h00, 2'b00, 1'b1, 10'h100);
      step(1'b0, 1'b1, 8'h00, 2'b00, 1'b1, 10'h3FF);
      step(1'b0, 1'b1, 8'h00, 2'b00, 1'b1, 10'h100);
      // XNOR path.
      step(1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 10'h354);
      step(1'b0, 1'b1, 8'hFF, 2'b00, 1'b1, 10'h200);
      // Disparity cleared by a single control character.
      step(1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 10'h354);
      step(1'b0, 1'b1, 8'h00, 2'b00, 1'b1, 10'h100);
      step(1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 10'h354);
      step(1'b0, 1'b1, 8'h00, 2'b00, 1'b1, 10'h100);
      // Random soak with occasional resets.
      rst_left = 0;
      for (int i = 0; i < 20000; i++) begin
         if (rst_left == 0 && $urandom_range(0, 199) == 0) rst_left = $urandom_range(1, 3);
         if (rst_left > 0) begin
            rst_left--;
            step(1'b1, 1'($urandom), 8'($urandom), 2'($urandom), 1'b0, 10'h0);
         end else begin
            step(1'b0, ($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom),
                 1'b0, 10'h0);
         end
      end
      step(1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 10'h0);
      step(1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 10'h0);
      @(posedge clk);
      #2;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
